// File: rtl/node_exp_rebase_pkg.sv
// Shared header for the node exponent rebase stage:
// buffer geometry, bf16 field positions and line bundle.
package node_exp_rebase_pkg;

  localparam int LOG2_LINES = 11;
  localparam int LINES      = 2 ** LOG2_LINES;
  localparam int EXP_BIAS   = 127;

  localparam int BF_SIGN   = 15;
  localparam int BF_EXP_HI = 14;
  localparam int BF_EXP_LO = 7;
  localparam int BF_MAN_HI = 6;

  typedef logic [LOG2_LINES-1:0] cnt_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  scale;
    logic [63:0] data;
  } line_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DRAIN,
    R_DONE
  } rd_state_e;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM, one-cycle registered read
// with a matching read-data-valid strobe.
module bram_sdp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_vld <= 1'b0;
    else     rd_data_vld <= rd_en;
  end

endmodule

// File: rtl/node_exp_rebase_lane.sv
// One bf16 lane rebased so the node max exponent lands on the bias;
// zero/denormal inputs and underflows flush to +0.
module bf16_exp_rebase
  import node_exp_rebase_pkg::*;
(
  input  logic [15:0] lane_in,
  input  logic [7:0]  max_exp,
  output logic [15:0] lane_out
);

  logic       s;
  logic [7:0] e;
  logic [6:0] m;
  logic [9:0] d;

  assign s = lane_in[BF_SIGN];
  assign e = lane_in[BF_EXP_HI:BF_EXP_LO];
  assign m = lane_in[BF_MAN_HI:0];
  assign d = {2'b00, e} - {2'b00, max_exp} + 10'(EXP_BIAS);

  // d[9] is the sign of the 10-bit difference
  always_comb begin
    lane_out = 16'h0000;
    if (e != 8'd0 && !d[9] && d != 10'd0) begin
      if (d >= 10'd255) lane_out = {s, 8'd254, m};
      else              lane_out = {s, d[7:0], m};
    end
  end

endmodule

// File: rtl/node_exp_rebase.sv
// Ping-pong node buffer: capture lines, wait for the node max exponent,
// replay each line rebased with the exponent as its scale tag.
module node_exp_rebase
  import node_exp_rebase_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           in_data,
  input  logic                  in_vld,
  input  logic [LOG2_LINES-1:0] num_lines_minusone,
  input  logic [7:0]            max_exp,
  input  logic                  max_exp_vld,
  output logic [63:0]           out_data,
  output logic [7:0]            out_scale,
  output logic                  out_last,
  output logic                  out_vld,
  input  logic                  out_ready,
  output logic                  ovf_err
);

  logic            wbank, rbank, ebank;
  logic [1:0]      full, full_nx;
  logic [1:0]      exp_ok, exp_ok_nx;
  cnt_t            wr_cnt, rd_cnt, wr_n;
  cnt_t [1:0]      nlm;
  logic [1:0][7:0] exp_reg;
  rd_state_e       state;

  logic free_now, wr_busy, ex_busy;
  logic wr_ok, wr_last, ex_ok;

  logic        rd_en, rd_vld, rd_last, slot_free;
  logic [63:0] rd_data;
  logic [8:0]  tag_q;
  line_t [1:0] fifo;
  logic [1:0]  cnt;
  logic        wp, rp;
  line_t       head;
  logic        head_vld, load, push_st, pop_st;
  logic [63:0] rebased;

  // A bank released this cycle is already usable by writer/exponent side
  assign free_now = (state == R_DONE) & rd_vld;
  assign wr_busy  = full[wbank] & ~(free_now & (rbank == wbank));
  assign ex_busy  = exp_ok[ebank] & ~(free_now & (rbank == ebank));
  assign wr_ok    = in_vld & ~wr_busy;
  assign ex_ok    = max_exp_vld & ~ex_busy;
  assign wr_n     = (wr_cnt == '0) ? num_lines_minusone : nlm[wbank];
  assign wr_last  = wr_ok & (wr_cnt == wr_n);

  always_comb begin
    full_nx   = full;
    exp_ok_nx = exp_ok;
    if (free_now) begin
      full_nx[rbank]   = 1'b0;
      exp_ok_nx[rbank] = 1'b0;
    end
    if (wr_last) full_nx[wbank] = 1'b1;
    if (ex_ok)   exp_ok_nx[ebank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank   <= 1'b0;
      ebank   <= 1'b0;
      wr_cnt  <= '0;
      nlm     <= '0;
      exp_reg <= '0;
      full    <= '0;
      exp_ok  <= '0;
      ovf_err <= 1'b0;
    end else begin
      full   <= full_nx;
      exp_ok <= exp_ok_nx;
      if ((in_vld & wr_busy) | (max_exp_vld & ex_busy))
        ovf_err <= 1'b1;
      if (wr_ok) begin
        if (wr_cnt == '0) nlm[wbank] <= num_lines_minusone;
        if (wr_last) begin
          wbank  <= ~wbank;
          wr_cnt <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (ex_ok) begin
        exp_reg[ebank] <= max_exp;
        ebank          <= ~ebank;
      end
    end
  end

  // Only issue when the skid FIFO can absorb the read in flight
  assign slot_free = (cnt == 2'd0) | ((cnt == 2'd1) & ~rd_vld);
  assign rd_en     = (state == R_DRAIN) & slot_free;
  assign rd_last   = (rd_cnt == nlm[rbank]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= R_IDLE;
      rd_cnt <= '0;
      rbank  <= 1'b0;
      tag_q  <= '0;
    end else begin
      if (rd_en) tag_q <= {rd_last, exp_reg[rbank]};
      unique case (state)
        R_IDLE: begin
          if (full[rbank] & exp_ok[rbank]) state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (rd_en) begin
            if (rd_last) begin
              rd_cnt <= '0;
              state  <= R_DONE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        R_DONE: begin
          if (rd_vld) begin
            rbank <= ~rbank;
            state <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  bram_sdp #(
    .ADDR_WIDTH(LOG2_LINES + 1),
    .DATA_WIDTH(64),
    .DEPTH     (2 * LINES)
  ) u_bram (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_ok),
    .wr_addr    ({wbank, wr_cnt}),
    .wr_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    ({rbank, rd_cnt}),
    .rd_data    (rd_data),
    .rd_data_vld(rd_vld)
  );

  // Fall-through skid FIFO in front of the output register
  assign head     = (cnt != 2'd0) ? fifo[rp] : {tag_q, rd_data};
  assign head_vld = (cnt != 2'd0) | rd_vld;
  assign load     = head_vld & (~out_vld | out_ready);
  assign pop_st   = load & (cnt != 2'd0);
  assign push_st  = rd_vld & ~(load & (cnt == 2'd0));

  for (genvar i = 0; i < 4; i++) begin : g_lane
    bf16_exp_rebase u_rb (
      .lane_in (head.data[16*i +: 16]),
      .max_exp (head.scale),
      .lane_out(rebased[16*i +: 16])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo      <= '0;
      cnt       <= 2'd0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_scale <= '0;
    end else begin
      if (push_st) begin
        fifo[wp] <= {tag_q, rd_data};
        wp       <= ~wp;
      end
      if (pop_st) rp <= ~rp;
      cnt <= cnt + {1'b0, push_st} - {1'b0, pop_st};
      if (load) begin
        out_vld   <= 1'b1;
        out_data  <= rebased;
        out_scale <= head.scale;
        out_last  <= head.last;
      end else if (out_ready) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_node_exp_rebase.sv
// Directed bench for node_exp_rebase: hand-computed rebase vectors,
// ordering, stalls, overflow and mid-drain reset.
module tb_node_exp_rebase;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_vld = 1'b0;
  logic [10:0] num_lines_minusone = '0;
  logic [7:0]  max_exp = '0;
  logic        max_exp_vld = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_scale;
  logic        out_last;
  logic        out_vld;
  logic        out_ready = 1'b0;
  logic        ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_err = 0;

  logic [72:0] q[$];
  logic [72:0] held;
  logic        held_v = 1'b0;

  node_exp_rebase dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_vld            (in_vld),
    .num_lines_minusone(num_lines_minusone),
    .max_exp           (max_exp),
    .max_exp_vld       (max_exp_vld),
    .out_data          (out_data),
    .out_scale         (out_scale),
    .out_last          (out_last),
    .out_vld           (out_vld),
    .out_ready         (out_ready),
    .ovf_err           (ovf_err)
  );

  always #5 clk = ~clk;

  // Transfers are decided at the next rising edge; inputs are settled here
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && (!out_vld || {out_last, out_scale, out_data} !== held))
        stall_err++;
      if (out_vld && out_ready)
        q.push_back({out_last, out_scale, out_data});
      held_v = out_vld && !out_ready;
      held   = {out_last, out_scale, out_data};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [72:0] obs,
                     input logic [72:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [10:0] nlm);
    in_data = d;
    num_lines_minusone = nlm;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] e);
    max_exp = e;
    max_exp_vld = 1'b1;
    tick();
    max_exp_vld = 1'b0;
  endtask

  function automatic logic [72:0] qget(input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic logic [72:0] ent(input logic last, input logic [7:0] sc,
                                     input logic [15:0] l3, input logic [15:0] l2,
                                     input logic [15:0] l1, input logic [15:0] l0);
    return {last, sc, l3, l2, l1, l0};
  endfunction

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_out_vld", 73'(out_vld), 73'(0));
    chk("rst_out_last", 73'(out_last), 73'(0));
    chk("rst_out_data", 73'(out_data), 73'(0));
    chk("rst_out_scale", 73'(out_scale), 73'(0));
    chk("rst_ovf_err", 73'(ovf_err), 73'(0));
    rst = 1'b0;
    tick();

    // single node n=4, latency and basic rebase
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send({4{16'h4300}}, 11'd3);
    pulse(8'd134);
    tick();
    tick();
    chk("lat_not_yet", 73'(out_vld), 73'(0));
    tick();
    chk("lat_3cyc", 73'(out_vld), 73'(1));
    repeat (10) tick();
    chk("n4_count", 73'(q.size()), 73'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("n4_line%0d", i), qget(i),
          ent(i == 3, 8'h86, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80));
    q.delete();

    // lane vectors, single-line nodes; third node reuses bank 0 as it frees
    send({16'h3F81, 16'hC300, 16'h8000, 16'h3F80}, 11'd0);
    pulse(8'd130);
    send({16'h2480, 16'h3F80, 16'h7F7F, 16'h0080}, 11'd0);
    pulse(8'd200);
    send({16'hBF80, 16'h0001, 16'h0080, 16'h7F80}, 11'd0);
    pulse(8'd0);
    repeat (12) tick();
    chk("lane_count", 73'(q.size()), 73'(3));
    chk("lane_max130", qget(0), ent(1'b1, 8'd130, 16'h3E01, 16'hC180, 16'h0000, 16'h3E00));
    chk("lane_max200", qget(1), ent(1'b1, 8'd200, 16'h0000, 16'h1B00, 16'h5AFF, 16'h0000));
    chk("lane_max0", qget(2), ent(1'b1, 8'd0, 16'hFF00, 16'h0000, 16'h4000, 16'h7F00));
    chk("lane_no_ovf", 73'(ovf_err), 73'(0));
    q.delete();

    // back-to-back n=8 nodes, node0 exponent during node1 lines
    for (int i = 0; i < 16; i++) begin
      in_data = (i < 8) ? {4{16'(16'h4300 + i)}} : {4{16'(16'h4100 + i - 8)}};
      num_lines_minusone = 11'd7;
      in_vld = 1'b1;
      max_exp = 8'd134;
      max_exp_vld = (i == 10);
      tick();
    end
    in_vld = 1'b0;
    max_exp_vld = 1'b0;
    pulse(8'd131);
    repeat (30) tick();
    chk("b2b_count", 73'(q.size()), 73'(16));
    for (int i = 0; i < 16; i++) begin
      logic [15:0] l;
      l = (i < 8) ? 16'(16'h3F80 + i) : 16'(16'h3F00 + i - 8);
      chk($sformatf("b2b_line%0d", i), qget(i),
          ent(i == 7 || i == 15, (i < 8) ? 8'h86 : 8'h83, l, l, l, l));
    end
    q.delete();

    // random backpressure, n=16
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send({4{16'(16'h4000 | i)}}, 11'd15);
    end
    pulse(8'd128);
    for (int i = 0; i < 80; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    repeat (20) tick();
    chk("bp_count", 73'(q.size()), 73'(16));
    for (int i = 0; i < 16; i++)
      chk($sformatf("bp_line%0d", i), qget(i),
          ent(i == 15, 8'd128, 16'(16'h3F80 | i), 16'(16'h3F80 | i),
              16'(16'h3F80 | i), 16'(16'h3F80 | i)));
    q.delete();

    // both banks full with consumer stalled, third node dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({4{16'(16'h4300 + i)}}, 11'd3);
    pulse(8'd134);
    for (int i = 0; i < 4; i++) send({4{16'(16'h4100 + i)}}, 11'd3);
    pulse(8'd131);
    repeat (5) tick();
    chk("ovf_before", 73'(ovf_err), 73'(0));
    for (int i = 0; i < 4; i++) send({4{16'h5555}}, 11'd3);
    chk("ovf_after", 73'(ovf_err), 73'(1));
    out_ready = 1'b1;
    repeat (30) tick();
    chk("ovf_count", 73'(q.size()), 73'(8));
    for (int i = 0; i < 8; i++) begin
      logic [15:0] l;
      l = (i < 4) ? 16'(16'h3F80 + i) : 16'(16'h3F00 + i - 4);
      chk($sformatf("ovf_line%0d", i), qget(i),
          ent(i == 3 || i == 7, (i < 4) ? 8'h86 : 8'h83, l, l, l, l));
    end
    chk("stall_stable", 73'(stall_err), 73'(0));

    // reset pulsed mid-drain, then a fresh n=2 node
    for (int i = 0; i < 8; i++) send({4{16'(16'h4300 + i)}}, 11'd7);
    pulse(8'd134);
    repeat (3) tick();
    chk("mid_vld_before", 73'(out_vld), 73'(1));
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 73'(out_vld), 73'(0));
    chk("mid_rst_data", 73'({out_last, out_scale, out_data}), 73'(0));
    chk("mid_rst_ovf", 73'(ovf_err), 73'(0));
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    tick();
    for (int i = 0; i < 2; i++) send({4{16'(16'h3F80 + i)}}, 11'd1);
    pulse(8'd130);
    repeat (10) tick();
    chk("post_rst_count", 73'(q.size()), 73'(2));
    for (int i = 0; i < 2; i++)
      chk($sformatf("post_rst_line%0d", i), qget(i),
          ent(i == 1, 8'd130, 16'(16'h3E00 + i), 16'(16'h3E00 + i),
              16'(16'h3E00 + i), 16'(16'h3E00 + i)));
    chk("post_rst_ovf", 73'(ovf_err), 73'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
